// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [3:0]        d_be_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              if_stall_o,
    output logic              d_stall_o,
    output logic [1:0]        dbg_state_o,
    output logic [3:0]        dbg_starve_cnt_o
);

    // Handshake: a requester holds req until its one-cycle ack; mem_req_o and all
    // mem_* outputs stay stable from grant until the single-cycle mem_ack_i pulse.

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [3:0]        starve_q, starve_d;
    logic              d_grant;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        starve_d    = starve_q;
        d_grant     = 1'b0;

        case (state_q)
            IDLE: begin
                // Requests are only sampled here; nothing is remembered across cycles.
                d_grant = d_req_i && (!if_req_i || (starve_q < STARVE_LIM));
                if (d_grant) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    mem_be_d    = d_we_i ? d_be_i : 4'hF;
                    if (!if_req_i) begin
                        starve_d = 4'd0;
                    end else if (starve_q < STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_req_i) begin
                    state_d     = I_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    starve_d    = 4'd0;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (state_q == D_BUSY) begin
                        d_rdata_d = mem_rdata_i;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata_i;
                        if_ack_d   = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            starve_q    <= 4'd0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            starve_q    <= starve_d;
        end
    end

    assign mem_req_o        = mem_req_q;
    assign mem_we_o         = mem_we_q;
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign mem_be_o         = mem_be_q;
    assign if_rdata_o       = if_rdata_q;
    assign d_rdata_o        = d_rdata_q;
    assign if_ack_o         = if_ack_q;
    assign d_ack_o          = d_ack_q;
    // Stalls are the only combinational input-to-output paths.
    assign if_stall_o       = if_req_i & ~if_ack_q;
    assign d_stall_o        = d_req_i & ~d_ack_q;
    assign dbg_state_o      = state_q;
    assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then randomized traffic, all
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic [DW-1:0] if_rdata_o;
    logic          if_ack_o;
    logic          d_req_i = 1'b0;
    logic          d_we_i = 1'b0;
    logic [AW-1:0] d_addr_i = '0;
    logic [DW-1:0] d_wdata_i = '0;
    logic [3:0]    d_be_i = 4'h0;
    logic [DW-1:0] d_rdata_o;
    logic          d_ack_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_ack_i = 1'b0;
    logic          if_stall_o;
    logic          d_stall_o;
    logic [1:0]    dbg_state_o;
    logic [3:0]    dbg_starve_cnt_o;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .if_stall_o(if_stall_o), .d_stall_o(d_stall_o),
        .dbg_state_o(dbg_state_o), .dbg_starve_cnt_o(dbg_starve_cnt_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic          m_req, m_resp, m_own_d, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rdata, m_d_rdata;
    logic [3:0]    m_be;
    int            m_starve;
    bit            m_grants[$];   // 1 = data grant, 0 = fetch grant

    function automatic void model_reset();
        m_req = 0; m_resp = 0; m_own_d = 0; m_we = 0;
        m_addr = '0; m_wdata = '0; m_be = 4'h0;
        m_if_rdata = '0; m_d_rdata = '0; m_starve = 0;
    endfunction

    function automatic void model_step();
        bit d_wins;
        if (!rst) begin
            model_reset();
            return;
        end
        if (m_resp) begin
            m_resp = 0;
        end else if (m_req) begin
            if (mem_ack_i) begin
                if (m_own_d) m_d_rdata = mem_rdata_i;
                else         m_if_rdata = mem_rdata_i;
                m_req = 0; m_resp = 1;
            end
        end else begin
            d_wins = d_req_i && (!if_req_i || m_starve < SMAX);
            if (d_wins) begin
                m_req = 1; m_own_d = 1; m_addr = d_addr_i; m_we = d_we_i;
                m_wdata = d_wdata_i; m_be = d_we_i ? d_be_i : 4'hF;
                m_starve = if_req_i ? ((m_starve + 1 > SMAX) ? SMAX : m_starve + 1) : 0;
                m_grants.push_back(1'b1);
            end else if (if_req_i) begin
                m_req = 1; m_own_d = 0; m_addr = if_addr_i; m_we = 0; m_be = 4'hF;
                m_starve = 0;
                m_grants.push_back(1'b0);
            end
        end
    endfunction

    function automatic logic [7:0] grant_pat(input int n);
        logic [7:0] p = '0;
        for (int i = 0; i < n; i++)
            p = {p[6:0], (i < m_grants.size()) ? m_grants[i] : 1'b0};
        return p;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("mem_req", mem_req_o, m_req);
        if (m_req) begin
            check("mem_addr", mem_addr_o, m_addr);
            check("mem_we", mem_we_o, m_we);
            check("mem_be", mem_be_o, m_be);
            if (m_we) check("mem_wdata", mem_wdata_o, m_wdata);
        end
        if (!rst) begin
            check("rst_mem_addr", mem_addr_o, 0);
            check("rst_mem_wdata", mem_wdata_o, 0);
            check("rst_mem_be", mem_be_o, 0);
            check("rst_mem_we", mem_we_o, 0);
        end
        check("if_ack", if_ack_o, m_resp && !m_own_d);
        check("d_ack", d_ack_o, m_resp && m_own_d);
        check("if_rdata", if_rdata_o, m_if_rdata);
        check("d_rdata", d_rdata_o, m_d_rdata);
        check("if_stall", if_stall_o, if_req_i && !(m_resp && !m_own_d));
        check("d_stall", d_stall_o, d_req_i && !(m_resp && m_own_d));
        check("starve_cnt", dbg_starve_cnt_o, m_starve);
    end

    // ---------------- memory responder / driver tasks ----------------
    int            lat_cfg = 1;
    bit            rand_lat = 0;
    bit            spurious_en = 0;
    bit            armed = 0;
    int            lat_left = 0;
    logic [DW-1:0] resp_data = '0;

    task automatic fire();
        mem_ack_i   = 1'b1;
        mem_rdata_i = rand_lat ? DW'($urandom) : resp_data;
        armed       = 0;
    endtask

    task automatic drive_mem();
        mem_ack_i   = 1'b0;
        mem_rdata_i = DW'($urandom);
        if (armed) begin
            lat_left--;
            if (lat_left <= 0) fire();
        end else if (mem_req_o) begin
            armed    = 1;
            lat_left = rand_lat ? int'($urandom_range(0, 4)) : lat_cfg;
            if (lat_left == 0) fire();
        end else if (spurious_en && $urandom_range(0, 9) == 0) begin
            mem_ack_i = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        drive_mem();
    endtask

    task automatic wait_ack(input string name, input bit want_d, input int max, output int cycles);
        cycles = 0;
        while (!(want_d ? d_ack_o : if_ack_o) && cycles < max) begin
            tick();
            cycles++;
        end
        if (!(want_d ? d_ack_o : if_ack_o)) begin
            n_checks++; n_fail++;
            $display("FAIL %s: no ack within %0d cycles", name, max);
        end
    endtask

    task automatic set_d(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [3:0] be);
        d_req_i = 1'b1; d_we_i = we; d_addr_i = a; d_wdata_i = wd; d_be_i = be;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  cyc, nd, acks;
        bit  stall_ok, prev_req, if_done, d_done;
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        check("reset_mem_req", mem_req_o, 0);
        check("reset_starve", dbg_starve_cnt_o, 0);
        check("reset_if_rdata", if_rdata_o, 0);

        // single fetch, memory acks two cycles after the request
        lat_cfg = 2; resp_data = 32'h8C080004;
        if_req_i = 1'b1; if_addr_i = 32'h0040_0000;
        tick();
        check("t1_mem_req", mem_req_o, 1);
        check("t1_mem_addr", mem_addr_o, 32'h0040_0000);
        check("t1_mem_be", mem_be_o, 4'hF);
        wait_ack("t1_if_ack", 0, 20, cyc);
        check("t1_latency", cyc, 3);
        check("t1_if_rdata", if_rdata_o, 32'h8C080004);
        check("t1_if_stall", if_stall_o, 0);
        tick(); if_req_i = 1'b0;

        // simultaneous requests: data first, fetch after one idle cycle
        m_grants.delete(); lat_cfg = 1;
        if_req_i = 1'b1; if_addr_i = 32'h0040_0004;
        set_d(0, 32'h1001_0000, '0, 4'h0);
        tick();
        check("t2_first_addr", mem_addr_o, 32'h1001_0000);
        check("t2_starve", dbg_starve_cnt_o, 1);
        stall_ok = 1; cyc = 0;
        while (!d_ack_o && cyc < 20) begin
            if (!if_stall_o) stall_ok = 0;
            tick(); cyc++;
        end
        check("t2_d_acked", d_ack_o, 1);
        check("t2_if_stall_held", stall_ok, 1);
        tick(); d_req_i = 1'b0;
        tick();
        check("t2_if_addr", mem_addr_o, 32'h0040_0004);
        wait_ack("t2_if_ack", 0, 20, cyc);
        check("t2_order", grant_pat(2), 8'b10);
        tick(); if_req_i = 1'b0;

        // starvation guard
        m_grants.delete(); nd = 0; cyc = 0; prev_req = 0;
        if_req_i = 1'b1; if_addr_i = 32'h0040_0008;
        set_d(0, 32'h1001_0010, '0, 4'h0);
        while (nd < 5 && cyc < 200) begin
            tick(); cyc++;
            if (mem_req_o && !prev_req && mem_addr_o == 32'h0040_0008)
                check("t3_starve_clear", dbg_starve_cnt_o, 0);
            prev_req = mem_req_o;
            if (d_ack_o) nd++;
        end
        check("t3_d_count", nd, 5);
        tick(); d_req_i = 1'b0;
        wait_ack("t3_if_ack", 0, 20, cyc);
        check("t3_order", grant_pat(6), 8'b111101);
        tick(); if_req_i = 1'b0;

        // store with partial byte enables
        lat_cfg = 3; cyc = 0;
        set_d(1, 32'h1001_0008, 32'hDEADBEEF, 4'b0011);
        tick();
        while (!d_ack_o && cyc < 20) begin
            check("t4_mem_req", mem_req_o, 1);
            check("t4_mem_we", mem_we_o, 1);
            check("t4_mem_be", mem_be_o, 4'b0011);
            check("t4_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
            tick(); cyc++;
        end
        check("t4_d_ack", d_ack_o, 1);
        tick(); d_req_i = 1'b0; d_we_i = 1'b0; acks = 0;
        repeat (5) begin tick(); if (d_ack_o) acks++; end
        check("t4_single_ack", acks, 0);

        // long memory latency
        lat_cfg = 7; resp_data = 32'h1357_9BDF;
        set_d(0, 32'h1001_0020, '0, 4'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("t5_mem_req", mem_req_o, 1);
            check("t5_mem_addr", mem_addr_o, 32'h1001_0020);
            check("t5_d_stall", d_stall_o, 1);
            tick();
        end
        check("t5_d_ack", d_ack_o, 1);
        check("t5_d_stall_ack", d_stall_o, 0);
        check("t5_d_rdata", d_rdata_o, 32'h1357_9BDF);
        tick(); d_req_i = 1'b0;

        // reset in the middle of a transaction
        lat_cfg = 6;
        set_d(0, 32'h1001_0030, '0, 4'h0);
        tick(); tick(); tick();
        rst = 1'b0; model_reset(); d_req_i = 1'b0;
        #1;
        check("t6_req_drop", mem_req_o, 0);
        tick(); tick(); rst = 1'b1; acks = 0;
        repeat (8) begin tick(); if (d_ack_o || if_ack_o) acks++; end
        check("t6_no_ack", acks, 0);
        lat_cfg = 1; resp_data = 32'hCAFE_F00D;
        if_req_i = 1'b1; if_addr_i = 32'h0040_0100;
        wait_ack("t6_fresh_ack", 0, 20, cyc);
        check("t6_fresh_rdata", if_rdata_o, 32'hCAFE_F00D);
        tick(); if_req_i = 1'b0;

        // randomized traffic
        rand_lat = 1; spurious_en = 1; if_done = 0; d_done = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (if_ack_o) if_done = 1;
            else if (if_done || !if_req_i) begin
                if_done = 0;
                if ($urandom_range(0, 2) != 0) begin
                    if_req_i = 1'b1; if_addr_i = $urandom & 32'hFFFF_FFFC;
                end else if_req_i = 1'b0;
            end else if ($urandom_range(0, 39) == 0) if_req_i = 1'b0;
            if (d_ack_o) d_done = 1;
            else if (d_done || !d_req_i) begin
                d_done = 0;
                if ($urandom_range(0, 2) != 0)
                    set_d(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)));
                else d_req_i = 1'b0;
            end else if ($urandom_range(0, 39) == 0) d_req_i = 1'b0;
        end
        if_req_i = 1'b0; d_req_i = 1'b0; spurious_en = 0;
        repeat (30) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between the IF stage (read-only fetch) and the MEM stage (load/store).
- Serialises accesses over a req/ack memory handshake that tolerates variable latency.
- Returns per-requester acknowledge and stall signals; the hazard unit and pipeline registers use the stalls to freeze stages (pstop path).
- Data port has priority, with a starvation guard that forces an IF grant after STARVE_MAX consecutive data grants.

Parameters:
ADDR_W  32  address width, byte address
DATA_W  32  data width
STARVE_MAX  4  consecutive data grants allowed while IF is waiting; range 1..15

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
if_req_i  in  1  fetch request; held until if_ack_o
if_addr_i  in  ADDR_W  fetch address
if_rdata_o  out  DATA_W  fetched word; valid while if_ack_o=1
if_ack_o  out  1  one-cycle fetch-complete pulse
d_req_i  in  1  data request; held until d_ack_o
d_we_i  in  1  1=store, 0=load
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_be_i  in  4  store byte enables
d_rdata_o  out  DATA_W  load data; valid while d_ack_o=1
d_ack_o  out  1  one-cycle data-complete pulse
mem_req_o  out  1  memory request, registered
mem_we_o  out  1  memory write enable, registered
mem_addr_o  out  ADDR_W  registered address
mem_wdata_o  out  DATA_W  registered write data
mem_be_o  out  4  registered byte enables (4'hF for fetches)
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion, single-cycle pulse
if_stall_o  out  1  if_req_i & ~if_ack_o
d_stall_o  out  1  d_req_i & ~d_ack_o

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; mem_req_o, mem_we_o, if_ack_o, d_ack_o=0; mem_addr_o, mem_wdata_o, if_rdata_o, d_rdata_o=0; mem_be_o=0; starve_cnt=0.
- Reset mid-transaction aborts the transaction: mem_req_o drops immediately and no ack is generated.
- States: IDLE, I_BUSY, D_BUSY, RESP.
- IDLE arbitration:
  - Data grant: d_req_i=1 and (if_req_i=0 or starve_cnt<STARVE_MAX).
  - Otherwise IF grant: if_req_i=1.
  - No request: stay in IDLE.
  - In IDLE, req inputs are sampled only, never latched across cycles.
- On grant: latch addr/we/wdata/be into the mem_* registers; set mem_req_o=1 on the next edge; go to D_BUSY or I_BUSY.
  - IF grant forces mem_we_o=0 and mem_be_o=4'hF.
  - Data load forces mem_be_o=4'hF; data store passes d_be_i.
- BUSY states: mem_req_o and all mem_* outputs hold stable until mem_ack_i=1.
  - On mem_ack_i: capture mem_rdata_i into the owner's rdata register; clear mem_req_o; go to RESP.
- RESP: owner's ack_o=1 for exactly this cycle; then IDLE.
  - Minimum transaction: request seen in cycle 0, mem_req_o high in cycle 1, ack_o in cycle k+1 where k is the mem_ack_i cycle.
  - Back-to-back transactions are separated by one IDLE cycle.
- rdata_o holds its last captured value between acks.
- Store acks update d_rdata_o with whatever mem_rdata_i carries; the consumer ignores it.
- starve_cnt:
  - +1 on each data grant made while if_req_i=1, saturating at STARVE_MAX.
  - Cleared on each IF grant.
  - Cleared on a data grant with if_req_i=0.
- Simultaneous if_req_i and d_req_i with starve_cnt<STARVE_MAX: data wins. With starve_cnt==STARVE_MAX: IF wins.
- A requester dropping req while it owns the port does not abort the transaction; ack still pulses.
- A request dropped before grant is simply not served.
- mem_ack_i in IDLE or RESP is ignored.
- A requester holding req through its ack cycle is re-arbitrated in the following IDLE cycle as a new request.
- Stalls are combinational from req and ack; no other path from inputs to outputs is combinational.

Test Plan:
- Reset then a single fetch: if_req_i=1, if_addr_i=0x00400000, memory acks 2 cycles after mem_req_o with 0x8C080004 -> mem_addr_o=0x00400000, mem_be_o=4'hF, if_ack_o pulse one cycle later, if_rdata_o=0x8C080004, if_stall_o=0 in the ack cycle.
- Simultaneous requests: if and d both high, d load at 0x10010000 -> data served first, if_stall_o=1 throughout; IF served after one IDLE cycle; starve_cnt=1 after the data grant.
- Starvation: if_req_i held, 5 consecutive data requests, STARVE_MAX=4 -> grant order D,D,D,D,I,D; starve_cnt=0 after the IF grant.
- Store: d_we_i=1, d_be_i=4'b0011, d_wdata_i=0xDEADBEEF, addr 0x10010008 -> mem_we_o=1, mem_be_o=4'b0011, mem_wdata_o=0xDEADBEEF stable until mem_ack_i; then one d_ack_o pulse.
- Variable latency: mem_ack_i delayed 7 cycles -> mem_req_o and mem_addr_o stable for all 7 cycles; d_stall_o=1 until the ack cycle.
- Reset mid-op: rst=0 asserted 2 cycles after mem_req_o=1 -> mem_req_o=0 immediately, no ack; a later mem_ack_i is ignored; a fresh request after reset is served normally.
